// File: rtl/mul12u_trunc_inv_div.sv
// Sequential restoring divider that undoes the truncated 12x12 multiplier:
// A_hat = floor((Z>>2K)/(B>>K)) << K, one quotient bit per clock.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// CALC  | one restoring-division iteration per edge, MSB of N first
// DONE  | result held on the outputs until out_ready
module mul12u_trunc_inv_div #(
    parameter int W = 12,
    parameter int K = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   z_in,
    input  logic [W-1:0]     b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     a_out,
    output logic [W-K-1:0]   rem_out,
    output logic             dz,
    output logic             sat
);
    localparam int D  = W - K;
    localparam int NW = 2 * D;
    localparam int CW = $clog2(NW + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          r_state;
    logic [NW-1:0]   r_n;
    logic [D-1:0]    r_dv;
    logic [D:0]      r_r;
    logic [NW-1:0]   r_q;
    logic [CW-1:0]   r_cnt;
    logic            r_out_valid;
    logic [W-1:0]    r_a;
    logic [D-1:0]    r_rem;
    logic            r_dz;
    logic            r_sat;

    logic [D:0]      w_rs;
    logic            w_ge;
    logic [D:0]      w_rn;
    logic [NW-1:0]   w_q;
    logic            w_sat;
    logic            w_unused;

    // R stays below Dv, so only its low D bits feed the next shifted value
    assign w_rs  = {r_r[D-1:0], r_n[NW-1]};
    assign w_ge  = (w_rs >= {1'b0, r_dv});
    assign w_rn  = w_ge ? (w_rs - {1'b0, r_dv}) : w_rs;
    assign w_q   = {r_q[NW-2:0], w_ge};
    assign w_sat = |w_q[NW-1:D];

    assign w_unused = ^{z_in[2*K-1:0], b_in[K-1:0], r_r[D]};

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign a_out     = r_a;
    assign rem_out   = r_rem;
    assign dz        = r_dz;
    assign sat       = r_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_n         <= '0;
            r_dv        <= '0;
            r_r         <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_rem       <= '0;
            r_dz        <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_n   <= z_in[2*W-1:2*K];
                        r_dv  <= b_in[W-1:K];
                        r_r   <= '0;
                        r_q   <= '0;
                        r_cnt <= '0;
                        if (b_in[W-1:K] == '0) begin
                            r_a         <= {{D{1'b1}}, {K{1'b0}}};
                            r_rem       <= '0;
                            r_dz        <= 1'b1;
                            r_sat       <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_r   <= w_rn;
                    r_q   <= w_q;
                    r_n   <= {r_n[NW-2:0], 1'b0};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(NW - 1)) begin
                        r_sat       <= w_sat;
                        r_a         <= {(w_sat ? {D{1'b1}} : w_q[D-1:0]), {K{1'b0}}};
                        r_rem       <= w_rn[D-1:0];
                        r_dz        <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
